// File: rtl/buf_reader_pkg.sv
// ---------------------------------------------------------------------------
// buf_reader_pkg : constants, slot field layout and FSM encoding shared by the
//                  key-entry buffer reader and the key-input collector.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package buf_reader_pkg;

  localparam int NUM_BUF    = 4;
  localparam int DEPTH      = 6;
  localparam int ENTRY_W    = 3;
  localparam int ID_W       = 2;
  localparam int IDX_W      = 3;
  localparam int BUF_W      = DEPTH * ENTRY_W;

  localparam int PAYLOAD_HI = 2;
  localparam int PAYLOAD_LO = 1;
  localparam int VALID_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/buf_slot_mux.sv
// ---------------------------------------------------------------------------
// buf_slot_mux : selects one slot out of a packed slot buffer.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module buf_slot_mux
  import buf_reader_pkg::*;
(
  input  logic [BUF_W-1:0]   i_buf,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [ENTRY_W-1:0] o_slot
);

  // Out-of-range indices return an empty slot, so a miss is the safe outcome.
  always_comb begin
    o_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_idx == IDX_W'(i)) begin
        o_slot = i_buf[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/buf_reader.sv
// ---------------------------------------------------------------------------
// buf_reader : round-robin drain of four packed slot buffers, presenting one
//              popped entry on a valid/ready port and strobing the slot clear.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module buf_reader
  import buf_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUF_W-1:0]      buffer1_i,
  input  logic [BUF_W-1:0]      buffer2_i,
  input  logic [BUF_W-1:0]      buffer3_i,
  input  logic [BUF_W-1:0]      buffer4_i,
  input  logic                  read_req,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ID_W+1:0]       out_data,
  output logic                  clr_valid,
  output logic [ID_W-1:0]       clr_buf,
  output logic [IDX_W-1:0]      clr_idx,
  output logic                  busy,
  output logic                  empty_o
);

  state_e                r_state;
  state_e                w_next_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]      r_rd_ptr [NUM_BUF];
  logic [IDX_W-1:0]      r_scan_cnt;
  logic [ID_W-1:0]       r_hit_buf;
  logic [ID_W+1:0]       r_out_data;
  logic                  r_empty;

  logic [BUF_W-1:0]      w_bufs [NUM_BUF];
  logic [ENTRY_W-1:0]    w_slot [NUM_BUF];
  logic [ID_W-1:0]       w_cand;
  logic [ENTRY_W-1:0]    w_cand_slot;
  logic                  w_hit;

  assign w_bufs[0] = buffer1_i;
  assign w_bufs[1] = buffer2_i;
  assign w_bufs[2] = buffer3_i;
  assign w_bufs[3] = buffer4_i;

  for (genvar g = 0; g < NUM_BUF; g++) begin : g_slot_mux
    buf_slot_mux u_slot_mux (
      .i_buf  (w_bufs[g]),
      .i_idx  (r_rd_ptr[g]),
      .o_slot (w_slot[g])
    );
  end

  // The 2-bit sum wraps naturally, giving (rr_ptr + scan_cnt) mod 4.
  assign w_cand      = r_rr_ptr + r_scan_cnt[ID_W-1:0];
  assign w_cand_slot = w_slot[w_cand];
  assign w_hit       = w_cand_slot[VALID_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // r_empty holds SCAN for one extra cycle so the empty pulse is seen while busy.
  always_comb begin
    w_next_state = r_state;
    out_valid    = 1'b0;
    clr_valid    = 1'b0;
    clr_buf      = '0;
    clr_idx      = '0;
    busy         = (r_state != ST_IDLE);
    empty_o      = r_empty;
    out_data     = r_out_data;
    case (r_state)
      ST_IDLE: begin
        if (read_req) w_next_state = ST_SCAN;
      end
      ST_SCAN: begin
        if (r_empty)    w_next_state = ST_IDLE;
        else if (w_hit) w_next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_valid    = 1'b1;
        clr_buf      = r_hit_buf;
        clr_idx      = r_rd_ptr[r_hit_buf];
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_scan_cnt <= '0;
      r_hit_buf  <= '0;
      r_out_data <= '0;
      r_empty    <= 1'b0;
      for (int b = 0; b < NUM_BUF; b++) begin
        r_rd_ptr[b] <= '0;
      end
    end else begin
      r_empty <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (read_req) r_scan_cnt <= '0;
        end
        ST_SCAN: begin
          if (!r_empty) begin
            if (w_hit) begin
              r_out_data <= {w_cand, w_cand_slot[PAYLOAD_HI:PAYLOAD_LO]};
              r_hit_buf  <= w_cand;
            end else if (r_scan_cnt == IDX_W'(NUM_BUF - 1)) begin
              r_empty <= 1'b1;
            end else begin
              r_scan_cnt <= r_scan_cnt + IDX_W'(1);
            end
          end
        end
        ST_CLEAR: begin
          r_rd_ptr[r_hit_buf] <= next_idx(r_rd_ptr[r_hit_buf]);
          r_rr_ptr            <= r_hit_buf + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_buf_reader.sv
// ---------------------------------------------------------------------------
// tb_buf_reader : directed scoreboard bench for buf_reader.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_buf_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] bufs [4];
  logic        read_req;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        clr_valid;
  logic [1:0]  clr_buf;
  logic [2:0]  clr_idx;
  logic        busy;
  logic        empty_o;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  q_data [$];
  logic [4:0]  q_clr  [$];

  always #5 clk = ~clk;

  buf_reader dut (
    .clk       (clk),
    .rst       (rst),
    .buffer1_i (bufs[0]),
    .buffer2_i (bufs[1]),
    .buffer3_i (bufs[2]),
    .buffer4_i (bufs[3]),
    .read_req  (read_req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .clr_valid (clr_valid),
    .clr_buf   (clr_buf),
    .clr_idx   (clr_idx),
    .busy      (busy),
    .empty_o   (empty_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every presented entry must match the queue head on each cycle it is held.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (q_data.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            chk("out_data", out_data, q_data[0]);
            if (out_ready) void'(q_data.pop_front());
          end
        end
        if (clr_valid) begin
          if (q_clr.size() == 0) begin
            chk("unexpected_clr_valid", 1, 0);
          end else begin
            chk("clr_buf_idx", {clr_buf, clr_idx}, q_clr[0]);
            void'(q_clr.pop_front());
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    read_req = 1'b0;
    q_data.delete();
    q_clr.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [3:0] d, input logic [1:0] cb, input logic [2:0] ci);
    q_data.push_back(d);
    q_clr.push_back({cb, ci});
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("busy_after_req", busy, 1);
  endtask

  task automatic wait_valid(input string name, input int exp_k);
    int  k    = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      tick();
      if (out_valid) begin
        seen = 1'b1;
        k    = i;
      end
    end
    chk(name, k, exp_k);
  endtask

  task automatic complete(input logic [1:0] cb, input logic [2:0] ci, input bit refill);
    out_ready = 1'b1;
    tick();
    chk("valid_drop_after_xfer", out_valid, 0);
    chk("clr_valid_after_xfer", clr_valid, 1);
    bufs[cb][ci*3 +: 3] = refill ? 3'b101 : 3'b000;
    tick();
    chk("clr_one_cycle", clr_valid, 0);
    chk("idle_after_clear", busy, 0);
  endtask

  task automatic pop(input logic [3:0] d, input int k, input logic [1:0] cb,
                     input logic [2:0] ci, input bit refill);
    issue(d, cb, ci);
    wait_valid("hit_latency", k);
    complete(cb, ci, refill);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    rst       = 1'b1;
    read_req  = 1'b0;
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) bufs[b] = '0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_all_outputs",
        {out_valid, out_data, clr_valid, clr_buf, clr_idx, busy, empty_o}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset while an entry is held in PRESENT.
    bufs[0] = 18'h00005;
    issue(4'b0010, 2'd0, 3'd0);
    wait_valid("rst_case_latency", 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_clr_valid", clr_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_busy", busy, 0);
    q_data.delete();
    q_clr.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single pop of slot 0 of buffer 1 again after reset.
    out_ready = 1'b1;
    pop(4'b0010, 1, 2'd0, 3'd0, 1'b0);

    // All buffers empty.
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("empty_pulse", empty_o, (i == 4) ? 1 : 0);
      chk("empty_busy", busy, (i <= 4) ? 1 : 0);
      chk("empty_no_valid", out_valid, 0);
    end

    // Round robin: buffer1 then buffer3.
    do_reset();
    bufs[0]   = 18'h00003;
    bufs[2]   = 18'h00007;
    out_ready = 1'b1;
    pop(4'b0001, 1, 2'd0, 3'd0, 1'b0);
    pop(4'b1011, 2, 2'd2, 3'd0, 1'b0);

    // Backpressure: rr_ptr now points at buffer4.
    bufs[3]   = 18'h00005;
    out_ready = 1'b0;
    issue(4'b1110, 2'd3, 3'd0);
    wait_valid("bp_latency", 1);
    for (int i = 0; i < 5; i++) begin
      bufs[0]  = (i % 2 == 0) ? 18'h3FFFF : 18'h00000;
      bufs[3]  = (i % 2 == 0) ? 18'h3FFFF : 18'h00005;
      read_req = (i % 2 == 1);
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_no_clear", clr_valid, 0);
    end
    bufs[0]  = '0;
    bufs[3]  = 18'h00005;
    read_req = 1'b0;
    complete(2'd3, 3'd0, 1'b0);
    tick();
    tick();
    chk("bp_no_extra_pop", busy, 0);

    // Wrap: buffer2 payloads 0,1,2,3,0,1; slot 0 refilled with payload 2.
    do_reset();
    for (int b = 0; b < 4; b++) bufs[b] = '0;
    bufs[1]   = 18'h19F59;
    out_ready = 1'b1;
    pop(4'b0100, 2, 2'd1, 3'd0, 1'b1);
    pop(4'b0101, 4, 2'd1, 3'd1, 1'b0);
    pop(4'b0110, 4, 2'd1, 3'd2, 1'b0);
    pop(4'b0111, 4, 2'd1, 3'd3, 1'b0);
    pop(4'b0100, 4, 2'd1, 3'd4, 1'b0);
    pop(4'b0101, 4, 2'd1, 3'd5, 1'b0);
    pop(4'b0110, 4, 2'd1, 3'd0, 1'b0);

    tick();
    tick();
    chk("data_queue_drained", q_data.size(), 0);
    chk("clr_queue_drained", q_clr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buf_reader.md
# buf_reader

Drain side of the key-entry buffering path. Four packed slot buffers are filled by the key-input collector, each with 6 slots of {payload[1:0], valid}. On each read request, buf_reader picks the next non-empty buffer in round-robin order and takes the oldest unread slot of that buffer. It presents {buffer id, payload} on a valid/ready output and sends the writer a one-cycle clear strobe so the writer can drop that slot's valid bit.

## Interface
- NUM_BUF, 4, number of source buffers (id width 2)
- DEPTH, 6, slots per buffer (index width 3)
- ENTRY_W, 3, bits per slot: [2:1] payload, [0] valid
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- buffer1_i..buffer4_i  in  18 each  packed slots; slot i at bits [3i+2:3i]
- read_req  in  1  request one pop; sampled only in IDLE
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data holds a popped entry
- out_data  out  4  {buf_id[1:0], payload[1:0]}
- clr_valid  out  1  one-cycle strobe: writer clears the slot named by clr_buf/clr_idx
- clr_buf  out  2  buffer id of the slot to clear
- clr_idx  out  3  slot index of the slot to clear
- busy  out  1  high whenever state is not IDLE
- empty_o  out  1  one-cycle pulse: request found no valid entry

## Operation
- State registers:
  - rr_ptr[1:0]: next buffer to try.
  - rd_ptr[b][2:0]: per-buffer read slot, one per buffer.
  - scan_cnt[2:0].
- FSM states: IDLE, SCAN, PRESENT, CLEAR.
- IDLE:
  - read_req=1 → SCAN, scan_cnt=0.
  - Otherwise stay in IDLE.
- SCAN, once per cycle:
  - Candidate c = (rr_ptr+scan_cnt) mod 4.
  - Hit when the valid bit of slot rd_ptr[c] in buffer c is 1. On a hit: register out_data={c, payload}, hit_buf=c, then go to PRESENT.
  - Miss with scan_cnt<3: scan_cnt++ and stay in SCAN.
  - Miss with scan_cnt=3: pulse empty_o, go to IDLE. rr_ptr and rd_ptr are unchanged.
- PRESENT:
  - out_valid=1; out_data is held stable.
  - out_valid=1 with out_ready=1 → CLEAR.
- CLEAR, for one cycle:
  - Outputs: clr_valid=1, clr_buf=hit_buf, clr_idx=rd_ptr[hit_buf].
  - Updates: rd_ptr[hit_buf] advances with wrap 5→0; rr_ptr=(hit_buf+1) mod 4 with wrap 3→0. Then go to IDLE.
- Input sampling: the buffer inputs are sampled only at the hit edge. Later changes on the inputs never alter the presented out_data.
- read_req while busy is ignored and not queued.
- Unread-slot overwrite by the writer is not detected. The reader returns whatever is valid at its rd_ptr.

## Timing
- Reset values (asynchronous, while rst=1):
  - State IDLE.
  - rr_ptr=0, all rd_ptr=0, scan_cnt=0.
  - out_valid=0, out_data=0, clr_valid=0, clr_buf=0, clr_idx=0, busy=0, empty_o=0.
- Reset asserted mid-operation: out_valid and clr_valid drop immediately; no clear strobe is issued.
- Latency, with read_req sampled at edge N:
  - busy=1 after N.
  - Hit on the k-th candidate (k=1..4): out_valid=1 after edge N+k.
  - All miss: empty_o=1 for the cycle after edge N+4; IDLE after N+5.
- Handshake:
  - A transfer occurs on an edge with out_valid and out_ready both high.
  - out_valid falls after that edge; clr_valid is high for the following cycle; IDLE follows.
  - Minimum request-to-request spacing is 4 cycles.
- out_ready held high before out_valid is harmless. The transfer takes effect on the first cycle out_valid is high.

## Structure
- Shared package holds:
  - Constants NUM_BUF=4, DEPTH=6, ENTRY_W=3.
  - FSM state encoding.
  - Field offsets (PAYLOAD_HI=2, PAYLOAD_LO=1, VALID_BIT=0), common to the key-input collector.
- One sub-module: buf_slot_mux. It is combinational: given an 18-bit packed buffer and a 3-bit index, it returns the 3-bit slot. Four instances are used, one per buffer, indexed by rd_ptr[b]; a 4:1 select by candidate follows.

## Test plan
- Reset: assert rst mid-PRESENT → all outputs 0 at once; after release, read_req pops slot 0 of buffer 1 again.
- Single pop:
  - Stimulus: buffer1_i=18'h00005 (slot 0 = {2'b10,1}), read_req at N, out_ready=1.
  - Required: out_valid after N+1 with out_data=4'b0010. Transfer on the next edge, then clr_valid=1, clr_buf=0, clr_idx=0 for one cycle.
- Empty: all buffers 0, read_req → no out_valid; empty_o single pulse after N+4; busy low after N+5.
- Round robin:
  - Stimulus: slot 0 valid in buffer1 (payload 01) and buffer3 (payload 11); two requests.
  - Required: out_data 4'b0001, then 4'b1011 with the second out_valid after edge N+2.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles during PRESENT; toggle buffer inputs and read_req.
  - Required: out_data stable, no extra pops, no clr_valid until the transfer.
- Wrap:
  - Stimulus: buffer2 with all 6 slots valid (payloads 0,1,2,3,0,1), writer model clearing on clr_valid and refilling slot 0 with payload 2; 7 requests.
  - Required: slots read in order 0..5 then slot 0 (payload 2), with clr_idx sequence 0,1,2,3,4,5,0.
